// File: rtl/pc_char_tx_pkg.sv
// Shared definitions for the character-to-PC transmitter: default PC constants,
// FSM state encoding and the character-to-PC mapping.
package pc_char_tx_pkg;

  localparam logic [63:0] MAD_BASE_DEF  = 64'h0000_0000_8000_0400;
  localparam logic [63:0] GOOD_TRAP_DEF = 64'h0000_0000_8000_1000;
  localparam logic [63:0] BAD_TRAP_DEF  = 64'h0000_0000_8000_1100;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EMIT = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_TRAP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_EMIT = ST_EMIT,
    S_GAP  = ST_GAP,
    S_TRAP = ST_TRAP,
    S_DONE = ST_DONE
  } tx_state_e;

  // The character lands in pc[8:1]; base bits [8:0] are zero by construction.
  function automatic logic [63:0] char_to_pc(input logic [63:0] base, input logic [7:0] ch);
    return base | {55'b0, ch, 1'b0};
  endfunction

endpackage

// File: rtl/pc_char_tx_if.sv
// Character input / PC commit bundle; the transmitter is the slave side.
interface pc_char_tx_if;
  logic        ch_valid;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic        finish_req;
  logic        fail_req;
  logic        pc_vld;
  logic [63:0] pc;
  logic        busy;
  logic        done;
  logic [15:0] char_cnt;

  modport master (
    output ch_valid, ch_data, finish_req, fail_req,
    input  ch_ready, pc_vld, pc, busy, done, char_cnt
  );

  modport slave (
    input  ch_valid, ch_data, finish_req, fail_req,
    output ch_ready, pc_vld, pc, busy, done, char_cnt
  );
endinterface

// File: rtl/pc_char_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty and a flush that
// takes priority over a simultaneous push or pop.
module pc_char_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_cnt, w_cnt_nxt;
  logic             r_full, r_empty;
  logic             w_push_ok, w_pop_ok;

  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && !r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push_ok && !w_pop_ok)      w_cnt_nxt = r_cnt + 1'b1;
    else if (w_pop_ok && !w_push_ok) w_cnt_nxt = r_cnt - 1'b1;
  end

  // NOTE: storage is deliberately not reset; only pointers and flags define
  // validity, which keeps the array mappable onto plain register files.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == DEPTH_C);
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/pc_char_tx.sv
// Turns a stream of characters into single-cycle PC commit pulses inside the
// print window, then ends with a good or bad trap PC.
module pc_char_tx
  import pc_char_tx_pkg::*;
#(
  parameter logic [63:0] MAD_BASE   = MAD_BASE_DEF,
  parameter logic [63:0] GOOD_TRAP  = GOOD_TRAP_DEF,
  parameter logic [63:0] BAD_TRAP   = BAD_TRAP_DEF,
  parameter int          GAP_CYCLES = 1,
  parameter int          FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  pc_char_tx_if.slave io_bus
);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  tx_state_e   r_state, w_nxt_state;
  logic [63:0] r_pc, w_pc_nxt;
  logic [7:0]  r_gap_cnt;
  logic [15:0] r_char_cnt;
  logic        r_fin_lat, r_fail_lat, r_rdy_en;
  logic        w_live, w_fail_now, w_fail_any, w_ch_ready, w_push, w_pop, w_dispatch;
  logic        w_full, w_empty;
  logic [7:0]  w_rd_data;

  // Requests are honoured only before the trap pulse has been chosen.
  assign w_live     = (r_state != S_TRAP) && (r_state != S_DONE);
  assign w_fail_now = io_bus.fail_req && w_live;
  assign w_fail_any = r_fail_lat || w_fail_now;
  assign w_ch_ready = r_rdy_en && !w_full && !r_fin_lat && !r_fail_lat && (r_state != S_DONE);
  assign w_push     = io_bus.ch_valid && w_ch_ready;

  pc_char_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (w_fail_now),
    .i_push    (w_push),
    .i_wr_data (io_bus.ch_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_pc_nxt    = r_pc;
    w_pop       = 1'b0;
    w_dispatch  = 1'b0;
    case (r_state)
      S_IDLE: w_dispatch = 1'b1;
      S_EMIT: begin
        if (GAP_CYCLES == 0) w_dispatch  = 1'b1;
        else                 w_nxt_state = S_GAP;
      end
      S_GAP:  if (r_gap_cnt == 8'd0) w_dispatch = 1'b1;
      S_TRAP: w_nxt_state = S_DONE;
      S_DONE: w_nxt_state = S_DONE;
      default: w_nxt_state = S_IDLE;
    endcase
    // Fail wins over queued data and over a pending finish.
    if (w_dispatch) begin
      if (w_fail_any) begin
        w_nxt_state = S_TRAP;
        w_pc_nxt    = BAD_TRAP;
      end else if (!w_empty) begin
        w_nxt_state = S_EMIT;
        w_pop       = 1'b1;
        w_pc_nxt    = char_to_pc(MAD_BASE, w_rd_data);
      end else if (r_fin_lat) begin
        w_nxt_state = S_TRAP;
        w_pc_nxt    = GOOD_TRAP;
      end else begin
        w_nxt_state = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_gap_cnt  <= '0;
      r_char_cnt <= '0;
      r_fin_lat  <= 1'b0;
      r_fail_lat <= 1'b0;
      r_rdy_en   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_state  <= w_nxt_state;
      r_pc     <= w_pc_nxt;
      if (r_state == S_EMIT) begin
        r_gap_cnt  <= GAP_LOAD;
        r_char_cnt <= r_char_cnt + 16'd1;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
      if (io_bus.finish_req && w_live) r_fin_lat  <= 1'b1;
      if (w_fail_now)                  r_fail_lat <= 1'b1;
    end
  end

  assign io_bus.ch_ready = w_ch_ready;
  assign io_bus.pc_vld   = (r_state == S_EMIT) || (r_state == S_TRAP);
  assign io_bus.pc       = r_pc;
  assign io_bus.busy     = !w_empty || ((r_state != S_IDLE) && (r_state != S_DONE));
  assign io_bus.done     = (r_state == S_DONE);
  assign io_bus.char_cnt = r_char_cnt;

endmodule
